// File: rtl/inv_mix_col_seq.sv
// Byte-serial AES InvMixColumns engine: one output byte per cycle through a
// single shared set of GF(2^8) x9/x11/x13/x14 constant multipliers.
module inv_mix_col_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [127:0] src;
    logic [1:0]   col, row, row1, row2, row3;
    logic [7:0]   b14, b11, b13, b9, res;
    logic [6:0]   wr_sh;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a2 ^ a;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a4 ^ a;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a4 ^ a2;
    endfunction

    // Byte idx lives at bit offset 120-8*idx (byte 0 is the MSB).
    function automatic logic [7:0] byte_at(input logic [127:0] d, input logic [3:0] idx);
        logic [127:0] t;
        t = d >> (7'd120 - {idx, 3'b000});
        return t[7:0];
    endfunction

    assign col  = cnt[3:2];
    assign row  = cnt[1:0];
    assign row1 = row + 2'd1;
    assign row2 = row + 2'd2;
    assign row3 = row + 2'd3;

    assign b14 = mul14(byte_at(src, {col, row}));
    assign b11 = mul11(byte_at(src, {col, row1}));
    assign b13 = mul13(byte_at(src, {col, row2}));
    assign b9  = mul9 (byte_at(src, {col, row3}));
    assign res = b14 ^ b11 ^ b13 ^ b9;

    assign wr_sh = 7'd120 - {cnt, 3'b000};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = in_bypass ? DONE : BUSY;
            BUSY:    if (cnt == 4'd15) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            src      <= 128'd0;
            out_data <= 128'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src <= in_data;
                        cnt <= 4'd0;
                        if (in_bypass) out_data <= in_data;
                    end
                end
                BUSY: begin
                    // Read-modify-write a single byte; untouched bytes keep the previous result.
                    out_data <= (out_data & ~(128'hff << wr_sh)) | ({120'd0, res} << wr_sh);
                    cnt      <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Bench for inv_mix_col_seq: directed vectors plus a random run, scored against
// a byte-array InvMixColumns model.
module tb_inv_mix_col_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = 128'd0;
    logic         in_bypass = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    inv_mix_col_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KA     = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KA_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] BYP    = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] ONES01 = {4{32'h01010101}};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int busy_cnt = 0;
    int rise_cyc = 0;
    int acc_cyc[$];
    logic [127:0] exp_q[$];
    logic rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply, AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] d);
        logic [7:0] s[16];
        logic [7:0] o[16];
        logic [127:0] r = 128'd0;
        for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                o[4*c+k] = gmul(s[4*c+k], 8'd14) ^ gmul(s[4*c+(k+1)%4], 8'd11) ^
                           gmul(s[4*c+(k+2)%4], 8'd13) ^ gmul(s[4*c+(k+3)%4], 8'd9);
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard / protocol monitor, sampled on the falling edge.
    initial begin
        logic prev_ov = 1'b0;
        logic stall = 1'b0;
        logic [127:0] prev_od = 128'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                n_acc = n_out;
                prev_ov = 1'b0;
                stall = 1'b0;
            end else begin
                chkb("ready_valid_exclusive", in_ready & out_valid, 1'b0);
                if (busy) busy_cnt++;
                if (out_valid && !prev_ov) rise_cyc = cyc;
                if (stall) begin
                    chkb("hold_valid", out_valid, 1'b1);
                    chk("hold_data", out_data, prev_od);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_bypass ? in_data : inv_mix(in_data));
                    acc_cyc.push_back(cyc + 1);
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chkb("unexpected_output", 1'b1, 1'b0);
                    else chk("out_data", out_data, exp_q.pop_front());
                    n_out++;
                end
                prev_ov = out_valid;
                prev_od = out_data;
                stall = out_valid & ~out_ready;
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic byp, input logic drop);
        int n = 0;
        in_data = d;
        in_bypass = byp;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chkb("send_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chkb("out_timeout", out_valid, 1'b1);
        @(negedge clk); #1;
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk); #1;
                if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chkb("post_rst_in_ready", in_ready, 1'b1);
        chkb("post_rst_out_valid", out_valid, 1'b0);

        // Pin the model with hand-computed values
        chk("model_gmul", {120'd0, gmul(8'h57, 8'h83)}, {120'd0, 8'hc1});
        chk("model_ka", inv_mix(KA), KA_EXP);
        chk("model_zero", inv_mix(128'd0), 128'd0);
        chk("model_01", inv_mix(ONES01), ONES01);

        // Known answer, latency and busy duration
        out_ready = 1'b1;
        busy_cnt = 0;
        send(KA, 1'b0, 1'b1);
        wait_out();
        chk("ka_data", out_data, KA_EXP);
        chkn("ka_latency", rise_cyc - acc_cyc[$], 16);
        chkn("ka_busy_cycles", busy_cnt, 16);

        // Bypass
        @(posedge clk); #1;
        busy_cnt = 0;
        send(BYP, 1'b1, 1'b1);
        wait_out();
        chk("byp_data", out_data, BYP);
        chkn("byp_latency", rise_cyc - acc_cyc[$], 0);
        chkn("byp_busy_cycles", busy_cnt, 0);

        // Backpressure with an ignored in_valid pulse
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(KA, 1'b0, 1'b1);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chkb("bp_valid", out_valid, 1'b1);
            chkb("bp_in_ready", in_ready, 1'b0);
            chk("bp_data", out_data, KA_EXP);
            if (i == 4) begin
                in_data = '1;
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chkb("bp_release_in_ready", in_ready, 1'b1);
        chkb("bp_release_out_valid", out_valid, 1'b0);

        // Reset mid-BUSY abandons the operation
        send(KA, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chkb("midrst_in_ready", in_ready, 1'b1);
        chkb("midrst_out_valid", out_valid, 1'b0);
        chkb("midrst_busy", busy, 1'b0);
        chk("midrst_out_data", out_data, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chkb("midrst_no_output", out_valid, 1'b0);
        end

        // Back-to-back stream
        begin
            int base;
            int n;
            base = acc_cyc.size();
            out_ready = 1'b1;
            send(128'd0, 1'b0, 1'b0);
            send(KA, 1'b0, 1'b0);
            send(ONES01, 1'b0, 1'b1);
            n = 0;
            while (n_out != n_acc && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chkn("b2b_drain", n_out, n_acc);
            chkn("b2b_gap1", acc_cyc[base+1] - acc_cyc[base], 18);
            chkn("b2b_gap2", acc_cyc[base+2] - acc_cyc[base+1], 18);
            chk("b2b_last_data", out_data, ONES01);
        end

        // Random run with stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 3) == 0), 1'b1);
        begin
            int n = 0;
            while (n_out != n_acc && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chkn("final_queue_empty", exp_q.size(), 0);
        chkn("final_acc_vs_out", n_out, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
